camera_wr_packer: RTL and testbench
===================================

CAMERA_WR_PACKER -- requirements
Module: camera_wr_packer

Interface
REQ-001 Parameter FRAME_BASE_0, default 25'h0000000, word address of frame buffer 0 in DDR.
REQ-002 Parameter FRAME_BASE_1, default 25'h0040000, word address of frame buffer 1 in DDR.
REQ-003 Parameter WORDS_PER_FRAME, default 38400, number of 128-bit words per frame (640x480 RGB565).
REQ-004 Parameter STAGE_DEPTH, default 4, depth of the packed-word staging buffer; power of two, at least 2.
REQ-005 clk_133M  input  1  single clock for the whole block.
REQ-006 rst_133M  input  1  reset; asynchronous, active-high.
REQ-007 init_done  input  1  DDR initialisation complete.
REQ-008 frame_start  input  1  single-cycle start-of-frame pulse from the camera capture stage.
REQ-009 pixel_valid  input  1  pixel_data is valid this cycle.
REQ-010 pixel_data  input  16  RGB565 pixel.
REQ-011 ram_busy  input  1  busy from the DDR request arbiter; no request may be issued while it is high.
REQ-012 camera_wr_req  output  1  single-cycle write request to the DDR request arbiter.
REQ-013 camera_wr_address  output  25  DDR word address; valid while camera_wr_req is high.
REQ-014 camera_wr_data  output  128  packed pixels; valid while camera_wr_req is high.
REQ-015 frame_done  output  1  single-cycle pulse on the cycle the last word of a frame is requested.
REQ-016 active_buf  output  1  index of the buffer currently being written.
REQ-017 overflow  output  1  sticky; set when a packed word is dropped.

Function
REQ-018 FSM states: WAIT_SOF, CAPTURE, DRAIN.
- WAIT_SOF -> CAPTURE on frame_start with init_done high.
- CAPTURE -> DRAIN when word WORDS_PER_FRAME-1 enters staging.
- DRAIN -> WAIT_SOF when staging is empty and frame_done has pulsed.
REQ-019 In CAPTURE, each pixel_valid pixel fills lane pix_cnt (0..7); lane k occupies bits [16k+15:16k]. Pixel 0 of each word is in bits [15:0].
REQ-020 When lane 7 is written, the completed word and its address (base + word_idx) are pushed to staging on the next cycle, and pix_cnt wraps to 0.
REQ-021 word_idx increments modulo 2^25 after each push; it is reset to 0 on each accepted frame_start.
REQ-022 Pixels arriving in WAIT_SOF or DRAIN are ignored; overflow is not set by them.
REQ-023 A push into a full staging buffer drops that word, sets overflow, and still advances word_idx.
REQ-024 camera_wr_req is registered. It is asserted for exactly one cycle when staging is non-empty, ram_busy is low and init_done is high; that entry is popped in the same cycle.
REQ-025 At most one request per cycle. When the previous cycle issued a request, the next request is spaced by at least one idle cycle (back-to-back requests are forbidden).
REQ-026 Latency: the 8th pixel sampled at cycle N gives the earliest camera_wr_req at cycle N+2.
REQ-027 A frame_start received in CAPTURE or DRAIN aborts the frame: the partial word is discarded, staging is flushed, pix_cnt and word_idx are cleared, and the block re-enters CAPTURE. frame_done does not pulse for the aborted frame.
REQ-028 A simultaneous frame_start and pixel_valid: the pixel becomes lane 0 of the new frame.
REQ-029 When init_done is low, frame_start is ignored and no request is issued.

Reset
REQ-030 The following clear asynchronously on rst_133M: FSM to WAIT_SOF, pix_cnt, word_idx, staging pointers, camera_wr_req, camera_wr_address, camera_wr_data, frame_done, active_buf and overflow (all 0).
REQ-031 When rst_133M is asserted mid-frame, all staged words are lost and no request is issued until the next frame_start after release.

Configuration
REQ-032 Macro CAM_PACK_DBUF_EN:
- Defined: active_buf toggles on each frame_done, and the base address is FRAME_BASE_0 when active_buf=0 or FRAME_BASE_1 when active_buf=1. Aborted frames do not toggle active_buf.
- Undefined: the base is always FRAME_BASE_0 and active_buf is tied to 0.

Verification
REQ-033 init_done=1, frame_start, then 8 pixels 16'h0001..16'h0008 with ram_busy=0 -> one camera_wr_req, data 128'h0008_0007_0006_0005_0004_0003_0002_0001, address 25'h0, 2 cycles after the last pixel.
REQ-034 WORDS_PER_FRAME=2, 16 pixels -> requests at addresses 0 and 1; frame_done with the second request; FSM returns to WAIT_SOF; extra pixels ignored.
REQ-035 ram_busy held high, 6 words packed with STAGE_DEPTH=4 -> overflow=1 and no requests. After ram_busy drops, exactly 4 requests are issued at addresses 0..3.
REQ-036 frame_start after 3 pixels of word 5 -> no request for the partial word; the next word is requested at address 0.
REQ-037 CAM_PACK_DBUF_EN defined, two complete frames -> first frame at FRAME_BASE_0, second at FRAME_BASE_1, active_buf 0 then 1 then 0.
REQ-038 rst_133M pulsed with 2 words staged -> all outputs 0 asynchronously; no request issued after release without a new frame_start.

Source files
------------

// File: rtl/camera_wr_packer.sv
// camera_wr_packer: packs eight RGB565 pixels into one 128-bit DDR word and
// issues single-cycle, registered write requests to the DDR request arbiter.
// A small staging buffer decouples pixel packing from arbiter back-pressure.
// Optional double buffering is enabled by defining CAM_PACK_DBUF_EN: the
// frame base then alternates between FRAME_BASE_0 and FRAME_BASE_1 on every
// completed frame; otherwise the base is fixed to FRAME_BASE_0.
module camera_wr_packer #(
    parameter logic [24:0] FRAME_BASE_0    = 25'h0000000,
    parameter logic [24:0] FRAME_BASE_1    = 25'h0040000,
    parameter int          WORDS_PER_FRAME = 38400,
    parameter int          STAGE_DEPTH     = 4
) (
    input  logic         clk_133M,
    input  logic         rst_133M,
    input  logic         init_done,
    input  logic         frame_start,
    input  logic         pixel_valid,
    input  logic [15:0]  pixel_data,
    input  logic         ram_busy,
    output logic         camera_wr_req,
    output logic [24:0]  camera_wr_address,
    output logic [127:0] camera_wr_data,
    output logic         frame_done,
    output logic         active_buf,
    output logic         overflow
);
    localparam int          AW        = (STAGE_DEPTH > 1) ? $clog2(STAGE_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(STAGE_DEPTH);
    localparam logic [24:0] LAST_IDX  = 25'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {WAIT_SOF, CAPTURE, DRAIN} state_t;

    state_t        state_reg;
    logic [2:0]    pix_cnt_reg;
    logic [24:0]   word_idx_reg;
    logic          pend_valid_reg;
    logic          pend_last_reg;
    logic [24:0]   pend_addr_reg;
    logic [127:0]  pend_data_reg;
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          done_seen_reg;

    // Staging buffer storage (no reset; validity is carried by the pointers)
    logic [24:0]   stage_addr_mem [STAGE_DEPTH];
    logic [127:0]  stage_data_mem [STAGE_DEPTH];
    logic          stage_last_mem [STAGE_DEPTH];

    // Lanes 0..6 of the word being assembled; lane 7 comes straight from pixel_data
    logic [111:0]  lanes;

    logic          sof_accept;
    logic          take_pixel;
    logic [2:0]    lane_sel;
    logic          word_done;
    logic [AW:0]   stage_cnt;
    logic          stage_full;
    logic          stage_empty;
    logic          push_ok;
    logic          issue;
    logic [24:0]   base_addr;

    // A frame start is honoured in any state once DDR is initialised; a pixel
    // arriving with it becomes lane 0 of the new frame.
    assign sof_accept  = frame_start & init_done;
    assign take_pixel  = pixel_valid & (sof_accept | (state_reg == CAPTURE));
    assign lane_sel    = sof_accept ? 3'd0 : pix_cnt_reg;
    assign word_done   = take_pixel & (lane_sel == 3'd7);
    assign stage_cnt   = wr_ptr_reg - rd_ptr_reg;
    assign stage_full  = (stage_cnt == DEPTH_CNT);
    assign stage_empty = (wr_ptr_reg == rd_ptr_reg);
    assign push_ok     = pend_valid_reg & ~stage_full & ~sof_accept;
    // The previous request blocks this cycle, so requests never run back-to-back
    assign issue       = ~camera_wr_req & ~stage_empty & ~ram_busy & init_done & ~sof_accept;
    assign base_addr   = active_buf ? FRAME_BASE_1 : FRAME_BASE_0;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_lane
            logic [15:0] lane_reg;
            // Capture the pixel destined for this lane
            always_ff @(posedge clk_133M or posedge rst_133M) begin
                if (rst_133M) begin
                    lane_reg <= '0;
                end else if (take_pixel && (lane_sel == 3'(gi))) begin
                    lane_reg <= pixel_data;
                end
            end
            assign lanes[16*gi +: 16] = lane_reg;
        end
    endgenerate

    // Write the pending packed word into the staging buffer
    always_ff @(posedge clk_133M) begin
        if (push_ok) begin
            stage_addr_mem[wr_ptr_reg[AW-1:0]] <= pend_addr_reg;
            stage_data_mem[wr_ptr_reg[AW-1:0]] <= pend_data_reg;
            stage_last_mem[wr_ptr_reg[AW-1:0]] <= pend_last_reg;
        end
    end

    // Frame FSM, packing counters, staging pointers and registered request outputs
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            state_reg         <= WAIT_SOF;
            pix_cnt_reg       <= '0;
            word_idx_reg      <= '0;
            pend_valid_reg    <= 1'b0;
            pend_last_reg     <= 1'b0;
            pend_addr_reg     <= '0;
            pend_data_reg     <= '0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            done_seen_reg     <= 1'b0;
            camera_wr_req     <= 1'b0;
            camera_wr_address <= '0;
            camera_wr_data    <= '0;
            frame_done        <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            camera_wr_req <= 1'b0;
            frame_done    <= 1'b0;
            if (sof_accept) begin
                // New frame (or abort): drop partial word, pending word and staging
                state_reg      <= CAPTURE;
                pix_cnt_reg    <= pixel_valid ? 3'd1 : 3'd0;
                word_idx_reg   <= '0;
                pend_valid_reg <= 1'b0;
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                done_seen_reg  <= 1'b0;
            end else begin
                if (pend_valid_reg) begin
                    pend_valid_reg <= 1'b0;
                    word_idx_reg   <= word_idx_reg + 25'd1;
                    if (stage_full) begin
                        overflow <= 1'b1;
                        // A dropped last word must still let the frame finish draining
                        if (pend_last_reg) begin
                            done_seen_reg <= 1'b1;
                        end
                    end else begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                end
                if (take_pixel) begin
                    pix_cnt_reg <= pix_cnt_reg + 3'd1;
                    if (word_done) begin
                        pend_valid_reg <= 1'b1;
                        pend_last_reg  <= (word_idx_reg == LAST_IDX);
                        pend_addr_reg  <= base_addr + word_idx_reg;
                        pend_data_reg  <= {pixel_data, lanes};
                        if (word_idx_reg == LAST_IDX) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                if (issue) begin
                    camera_wr_req     <= 1'b1;
                    camera_wr_address <= stage_addr_mem[rd_ptr_reg[AW-1:0]];
                    camera_wr_data    <= stage_data_mem[rd_ptr_reg[AW-1:0]];
                    frame_done        <= stage_last_mem[rd_ptr_reg[AW-1:0]];
                    rd_ptr_reg        <= rd_ptr_reg + 1'b1;
                    if (stage_last_mem[rd_ptr_reg[AW-1:0]]) begin
                        done_seen_reg <= 1'b1;
                    end
                end
                if ((state_reg == DRAIN) && stage_empty && !pend_valid_reg && done_seen_reg) begin
                    state_reg     <= WAIT_SOF;
                    done_seen_reg <= 1'b0;
                end
            end
        end
    end

`ifdef CAM_PACK_DBUF_EN
    logic active_buf_reg;

    // Flip to the other frame buffer each time a frame's last word is requested
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            active_buf_reg <= 1'b0;
        end else if (!sof_accept && issue && stage_last_mem[rd_ptr_reg[AW-1:0]]) begin
            active_buf_reg <= ~active_buf_reg;
        end
    end

    assign active_buf = active_buf_reg;
`else
    assign active_buf = 1'b0;
`endif

endmodule

// File: tb/tb_camera_wr_packer.sv
// Testbench for camera_wr_packer: randomized pixel frames checked against a
// word-level reference model (pixels grouped by eight, addressed base + index).
`timescale 1ns/1ps
module tb_camera_wr_packer;
    localparam logic [24:0] FB0   = 25'h0000000;
    localparam logic [24:0] FB1   = 25'h0040000;
    localparam int          WPF   = 8;
    localparam int          DEPTH = 4;
`ifdef CAM_PACK_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic         clk_133M = 1'b0;
    logic         rst_133M;
    logic         init_done;
    logic         frame_start;
    logic         pixel_valid;
    logic [15:0]  pixel_data;
    logic         busy_force;
    logic         busy_rand = 1'b0;
    logic         busy_rand_en;
    wire          ram_busy;
    logic         camera_wr_req;
    logic [24:0]  camera_wr_address;
    logic [127:0] camera_wr_data;
    logic         frame_done;
    logic         active_buf;
    logic         overflow;

    assign ram_busy = busy_rand_en ? busy_rand : busy_force;

    camera_wr_packer #(
        .FRAME_BASE_0    (FB0),
        .FRAME_BASE_1    (FB1),
        .WORDS_PER_FRAME (WPF),
        .STAGE_DEPTH     (DEPTH)
    ) dut (
        .clk_133M          (clk_133M),
        .rst_133M          (rst_133M),
        .init_done         (init_done),
        .frame_start       (frame_start),
        .pixel_valid       (pixel_valid),
        .pixel_data        (pixel_data),
        .ram_busy          (ram_busy),
        .camera_wr_req     (camera_wr_req),
        .camera_wr_address (camera_wr_address),
        .camera_wr_data    (camera_wr_data),
        .frame_done        (frame_done),
        .active_buf        (active_buf),
        .overflow          (overflow)
    );

    always #5 clk_133M = ~clk_133M;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_count = 0;
    int last_px_cyc = 0;
    bit exp_active = 1'b0;
    logic busy_s = 1'b0;
    int busy_run = 0;
    int busy_gap = 0;

    logic [24:0]  obs_addr [$];
    logic [127:0] obs_data [$];
    bit           obs_done [$];
    bit           obs_busy [$];
    int           obs_cyc  [$];
    logic [15:0]  frame_px [64];

    always @(posedge clk_133M) begin
        cyc    <= cyc + 1;
        busy_s <= ram_busy;
    end

    // Bursty busy: at most 3 busy cycles followed by at least 3 free cycles
    always @(negedge clk_133M) begin
        if (busy_run > 0) begin
            busy_rand <= 1'b1;
            busy_run  <= busy_run - 1;
        end else if (busy_gap > 0) begin
            busy_rand <= 1'b0;
            busy_gap  <= busy_gap - 1;
        end else begin
            busy_rand <= 1'b0;
            busy_run  <= $urandom_range(0, 3);
            busy_gap  <= 2;
        end
    end

    // Record every request away from the active edge
    always @(negedge clk_133M) begin
        if (camera_wr_req === 1'b1) begin
            obs_addr.push_back(camera_wr_address);
            obs_data.push_back(camera_wr_data);
            obs_done.push_back(frame_done === 1'b1);
            obs_busy.push_back(busy_s);
            obs_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic drive(input logic fs, input logic pv, input logic [15:0] pd);
        @(negedge clk_133M);
        frame_start = fs;
        pixel_valid = pv;
        pixel_data  = pd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic randomize_px();
        for (int i = 0; i < 64; i++) frame_px[i] = 16'($urandom);
    endtask

    task automatic send_px(input int first, input int count, input bit sof_first, input int max_gap);
        for (int i = first; i < first + count; i++) begin
            drive(sof_first && (i == first), 1'b1, frame_px[i]);
            last_px_cyc = cyc + 1;
            if (max_gap > 0 && i != first + count - 1) idle($urandom_range(0, max_gap));
        end
        drive(1'b0, 1'b0, 16'h0000);
    endtask

    function automatic logic [127:0] pack_word(input int k);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = frame_px[8*k + j];
        return w;
    endfunction

    function automatic logic [24:0] exp_base();
        return (DBUF && exp_active) ? FB1 : FB0;
    endfunction

    task automatic test_reset();
        rst_133M = 1'b1; init_done = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
        pixel_data = 16'h0; busy_force = 1'b0; busy_rand_en = 1'b0;
        repeat (3) @(negedge clk_133M);
        checks++; if (camera_wr_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", camera_wr_req); end
        checks++; if (camera_wr_address !== 25'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", camera_wr_address); end
        checks++; if (camera_wr_data !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", camera_wr_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (active_buf !== 1'b0) begin errors++; $display("FAIL reset_active_buf: got %b expected 0", active_buf); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst_133M = 1'b0;
        idle(2);
        $display("test_reset: done");
    endtask

    task automatic test_single_word();
        int start;
        logic [127:0] exp_w;
        exp_w = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        init_done = 1'b1; busy_force = 1'b0;
        start = obs_addr.size();
        drive(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) frame_px[i] = 16'(i + 1);
        send_px(0, 8, 1'b0, 0);
        idle(6);
        checks++; if (obs_addr.size() != start + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", obs_addr.size() - start, 1); end
        if (obs_addr.size() > start) begin
            checks++; if (obs_addr[start] !== exp_base()) begin errors++; $display("FAIL single_addr: got %h expected %h", obs_addr[start], exp_base()); end
            checks++; if (obs_data[start] !== exp_w) begin errors++; $display("FAIL single_data: got %h expected %h", obs_data[start], exp_w); end
            checks++; if (obs_cyc[start] != last_px_cyc + 2) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", obs_cyc[start], last_px_cyc + 2); end
            checks++; if (obs_done[start] !== 1'b0) begin errors++; $display("FAIL single_frame_done: got %b expected 0", obs_done[start]); end
        end
        $display("test_single_word: addr %h data %h", exp_base(), exp_w);
    endtask

    task automatic test_full_frame();
        int start, fd0, idx;
        logic [24:0] base;
        for (int f = 0; f < 2; f++) begin
            randomize_px();
            start = obs_addr.size(); fd0 = fd_count; base = exp_base();
            busy_rand_en = 1'b1;
            if (f == 1) drive(1'b1, 1'b0, 16'h0000);
            send_px(0, 64, f == 0, 2);
            for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 16'($urandom));
            drive(1'b0, 1'b0, 16'h0000);
            idle(40);
            busy_rand_en = 1'b0;
            checks++; if (obs_addr.size() - start != WPF) begin errors++; $display("FAIL frame%0d_count: got %0d expected %0d", f, obs_addr.size() - start, WPF); end
            for (int k = 0; k < WPF && start + k < obs_addr.size(); k++) begin
                idx = start + k;
                checks++; if (obs_addr[idx] !== base + 25'(k)) begin errors++; $display("FAIL frame%0d_addr%0d: got %h expected %h", f, k, obs_addr[idx], base + 25'(k)); end
                checks++; if (obs_data[idx] !== pack_word(k)) begin errors++; $display("FAIL frame%0d_data%0d: got %h expected %h", f, k, obs_data[idx], pack_word(k)); end
                checks++; if (obs_done[idx] !== (k == WPF - 1)) begin errors++; $display("FAIL frame%0d_done%0d: got %b expected %b", f, k, obs_done[idx], (k == WPF - 1)); end
                checks++; if (obs_busy[idx] !== 1'b0) begin errors++; $display("FAIL frame%0d_busy%0d: request issued with ram_busy %b expected 0", f, k, obs_busy[idx]); end
                if (k > 0) begin
                    checks++; if (obs_cyc[idx] - obs_cyc[idx-1] < 2) begin errors++; $display("FAIL frame%0d_spacing%0d: got %0d expected >=2", f, k, obs_cyc[idx] - obs_cyc[idx-1]); end
                end
            end
            checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL frame%0d_done_pulses: got %0d expected 1", f, fd_count - fd0); end
            if (DBUF) exp_active = ~exp_active;
            checks++; if (active_buf !== exp_active) begin errors++; $display("FAIL frame%0d_active_buf: got %b expected %b", f, active_buf, exp_active); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frame%0d_overflow: got %b expected 0", f, overflow); end
            $display("test_full_frame: frame %0d base %h words %0d", f, base, obs_addr.size() - start);
        end
    endtask

    task automatic test_init_low();
        int start, fd0;
        start = obs_addr.size(); fd0 = fd_count;
        init_done = 1'b0;
        randomize_px();
        send_px(0, 8, 1'b1, 0);
        idle(5);
        init_done = 1'b1;
        send_px(8, 8, 1'b0, 0);
        idle(8);
        checks++; if (obs_addr.size() != start) begin errors++; $display("FAIL init_low_sof_ignored: got %0d requests expected 0", obs_addr.size() - start); end
        randomize_px();
        send_px(0, 8, 1'b1, 0);
        init_done = 1'b0;
        idle(10);
        checks++; if (obs_addr.size() != start) begin errors++; $display("FAIL init_low_no_req: got %0d requests expected 0", obs_addr.size() - start); end
        init_done = 1'b1;
        idle(6);
        checks++; if (obs_addr.size() != start + 1) begin errors++; $display("FAIL init_high_req: got %0d requests expected 1", obs_addr.size() - start); end
        if (obs_addr.size() > start) begin
            checks++; if (obs_addr[start] !== exp_base()) begin errors++; $display("FAIL init_addr: got %h expected %h", obs_addr[start], exp_base()); end
            checks++; if (obs_data[start] !== pack_word(0)) begin errors++; $display("FAIL init_data: got %h expected %h", obs_data[start], pack_word(0)); end
        end
        checks++; if (fd_count != fd0) begin errors++; $display("FAIL init_frame_done: got %0d pulses expected 0", fd_count - fd0); end
        $display("test_init_low: requests %0d", obs_addr.size() - start);
    endtask

    task automatic test_abort();
        int start, fd0;
        bit act0;
        fd0 = fd_count; act0 = exp_active;
        randomize_px();
        start = obs_addr.size();
        send_px(0, 43, 1'b1, 0);
        idle(10);
        checks++; if (obs_addr.size() - start != 5) begin errors++; $display("FAIL abort_pre_count: got %0d expected 5", obs_addr.size() - start); end
        for (int k = 0; k < 5 && start + k < obs_addr.size(); k++) begin
            checks++; if (obs_addr[start+k] !== exp_base() + 25'(k)) begin errors++; $display("FAIL abort_pre_addr%0d: got %h expected %h", k, obs_addr[start+k], exp_base() + 25'(k)); end
            checks++; if (obs_data[start+k] !== pack_word(k)) begin errors++; $display("FAIL abort_pre_data%0d: got %h expected %h", k, obs_data[start+k], pack_word(k)); end
        end
        randomize_px();
        start = obs_addr.size();
        send_px(0, 8, 1'b1, 0);
        idle(6);
        checks++; if (obs_addr.size() - start != 1) begin errors++; $display("FAIL abort_post_count: got %0d expected 1", obs_addr.size() - start); end
        if (obs_addr.size() > start) begin
            checks++; if (obs_addr[start] !== exp_base()) begin errors++; $display("FAIL abort_post_addr: got %h expected %h", obs_addr[start], exp_base()); end
            checks++; if (obs_data[start] !== pack_word(0)) begin errors++; $display("FAIL abort_post_data: got %h expected %h", obs_data[start], pack_word(0)); end
        end
        // Abort with two words waiting in staging: they must be flushed
        busy_force = 1'b1;
        randomize_px();
        send_px(0, 16, 1'b1, 0);
        idle(3);
        randomize_px();
        start = obs_addr.size();
        send_px(0, 8, 1'b1, 0);
        busy_force = 1'b0;
        idle(8);
        checks++; if (obs_addr.size() - start != 1) begin errors++; $display("FAIL abort_flush_count: got %0d expected 1", obs_addr.size() - start); end
        if (obs_addr.size() > start) begin
            checks++; if (obs_addr[start] !== exp_base()) begin errors++; $display("FAIL abort_flush_addr: got %h expected %h", obs_addr[start], exp_base()); end
            checks++; if (obs_data[start] !== pack_word(0)) begin errors++; $display("FAIL abort_flush_data: got %h expected %h", obs_data[start], pack_word(0)); end
        end
        checks++; if (fd_count != fd0) begin errors++; $display("FAIL abort_frame_done: got %0d pulses expected 0", fd_count - fd0); end
        checks++; if (active_buf !== act0) begin errors++; $display("FAIL abort_active_buf: got %b expected %b", active_buf, act0); end
        $display("test_abort: partial word discarded, staging flushed");
    endtask

    task automatic test_overflow();
        int start;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_initial: got %b expected 0", overflow); end
        busy_force = 1'b1;
        randomize_px();
        start = obs_addr.size();
        send_px(0, 48, 1'b1, 0);
        idle(10);
        checks++; if (obs_addr.size() != start) begin errors++; $display("FAIL ovf_busy_no_req: got %0d requests expected 0", obs_addr.size() - start); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        busy_force = 1'b0;
        idle(15);
        checks++; if (obs_addr.size() - start != DEPTH) begin errors++; $display("FAIL ovf_drain_count: got %0d expected %0d", obs_addr.size() - start, DEPTH); end
        for (int k = 0; k < DEPTH && start + k < obs_addr.size(); k++) begin
            checks++; if (obs_addr[start+k] !== exp_base() + 25'(k)) begin errors++; $display("FAIL ovf_addr%0d: got %h expected %h", k, obs_addr[start+k], exp_base() + 25'(k)); end
            checks++; if (obs_data[start+k] !== pack_word(k)) begin errors++; $display("FAIL ovf_data%0d: got %h expected %h", k, obs_data[start+k], pack_word(k)); end
            if (k > 0) begin
                checks++; if (obs_cyc[start+k] - obs_cyc[start+k-1] != 2) begin errors++; $display("FAIL ovf_spacing%0d: got %0d expected 2", k, obs_cyc[start+k] - obs_cyc[start+k-1]); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        $display("test_overflow: drained %0d words", obs_addr.size() - start);
    endtask

    task automatic test_reset_mid_frame();
        int start;
        busy_force = 1'b1;
        randomize_px();
        send_px(0, 16, 1'b1, 0);
        idle(3);
        @(posedge clk_133M);
        #2;
        rst_133M = 1'b1;
        #1;
        checks++; if (camera_wr_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", camera_wr_req); end
        checks++; if (camera_wr_address !== 25'h0) begin errors++; $display("FAIL rst_mid_addr: got %h expected 0", camera_wr_address); end
        checks++; if (camera_wr_data !== 128'h0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", camera_wr_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_done: got %b expected 0", frame_done); end
        checks++; if (active_buf !== 1'b0) begin errors++; $display("FAIL rst_mid_active_buf: got %b expected 0", active_buf); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b expected 0", overflow); end
        @(negedge clk_133M);
        rst_133M = 1'b0; busy_force = 1'b0; exp_active = 1'b0;
        start = obs_addr.size();
        idle(15);
        randomize_px();
        send_px(0, 16, 1'b0, 0);
        idle(8);
        checks++; if (obs_addr.size() != start) begin errors++; $display("FAIL rst_mid_no_req: got %0d requests expected 0", obs_addr.size() - start); end
        randomize_px();
        send_px(0, 8, 1'b1, 0);
        idle(6);
        checks++; if (obs_addr.size() - start != 1) begin errors++; $display("FAIL rst_mid_new_count: got %0d expected 1", obs_addr.size() - start); end
        if (obs_addr.size() > start) begin
            checks++; if (obs_addr[start] !== FB0) begin errors++; $display("FAIL rst_mid_new_addr: got %h expected %h", obs_addr[start], FB0); end
            checks++; if (obs_data[start] !== pack_word(0)) begin errors++; $display("FAIL rst_mid_new_data: got %h expected %h", obs_data[start], pack_word(0)); end
        end
        $display("test_reset_mid_frame: staged words discarded");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_word();
        test_full_frame();
        test_init_low();
        test_abort();
        test_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
